uart_cmd_parser: RTL and testbench

Parses an ASCII command line received byte-by-byte from the UART receiver into two 16-bit unsigned operands and an operation code. Sits directly upstream of the calculator execution units (adder, shift-add multiplier). On a valid command it drives `src1`, `src2` and `op` and pulses `parser_done`. On a malformed command it pulses `parse_err` and discards input up to the end of the line.

---
 rtl/uart_cal_pkg.sv | 22 ++
 rtl/uart_cmd_parser_if.sv | 14 +
 rtl/uart_cmd_parser_dec_digit_acc.sv | 14 +
 rtl/uart_cmd_parser.sv | 110 +++++++++++
 tb/tb_uart_cmd_parser.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_cal_pkg.sv
// uart_cal_pkg: opcodes, ASCII constants and parser state encoding for the UART calculator
// Contents: OP_ADD/OP_SUB/OP_MUL, ASCII_* byte values, parser_state_t (3-bit FSM encoding)
package uart_cal_pkg;
    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_SP    = 8'h20;
    localparam logic [7:0] ASCII_0     = 8'h30;
    localparam logic [7:0] ASCII_9     = 8'h39;
    localparam logic [7:0] ASCII_PLUS  = 8'h2B;
    localparam logic [7:0] ASCII_MINUS = 8'h2D;
    localparam logic [7:0] ASCII_STAR  = 8'h2A;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_OP1,
        ST_OP2,
        ST_DONE,
        ST_ERR,
        ST_FLUSH
    } parser_state_t;
endpackage

// File: rtl/uart_cmd_parser_if.sv
// uart_cmd_parser_if: byte stream in, parsed command out, for the UART command parser
// Signals: rx_data/rx_valid (byte strobe), src1/src2/op (command), parser_done/parse_err (pulses)
// Modports: master drives the byte stream and sees results, slave is the parser
interface uart_cmd_parser_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [15:0] src1;
    logic [15:0] src2;
    logic [1:0]  op;
    logic        parser_done;
    logic        parse_err;
    modport master (output rx_data, rx_valid, input src1, src2, op, parser_done, parse_err);
    modport slave  (input rx_data, rx_valid, output src1, src2, op, parser_done, parse_err);
endinterface

// File: rtl/uart_cmd_parser_dec_digit_acc.sv
// dec_digit_acc: combinational acc*10 + digit with 16-bit overflow detection
// Ports: i_acc (16b accumulator), i_digit (4b decimal digit), o_result (16b), o_ovf (result > 65535)
module dec_digit_acc (
    input  logic [15:0] i_acc,
    input  logic [3:0]  i_digit,
    output logic [15:0] o_result,
    output logic        o_ovf
);
    logic [19:0] w_sum;
    // 20 bits hold 65535*10+9 so overflow is exact for any incoming acc
    assign w_sum    = ({4'd0, i_acc} << 3) + ({4'd0, i_acc} << 1) + {16'd0, i_digit};
    assign o_result = w_sum[15:0];
    assign o_ovf    = |w_sum[19:16];
endmodule

// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: parses "<digits><op><digits>CR" byte lines into src1/src2/op
// Ports: clk, n_rst (async active-low), bus (slave): rx_data/rx_valid in;
//        src1/src2/op (held until next DONE), parser_done/parse_err one-cycle pulses out
module uart_cmd_parser
    import uart_cal_pkg::*;
#(
    parameter int MAX_DIGITS = 5
) (
    input  logic             clk,
    input  logic             n_rst,
    uart_cmd_parser_if.slave bus
);
    localparam int CW = $clog2(MAX_DIGITS + 1);
    parser_state_t r_state;
    logic [15:0]   r_acc1, r_acc2, r_src1, r_src2;
    logic [1:0]    r_op_w, r_op;
    logic [CW-1:0] r_cnt;
    logic          r_err_cr, r_done, r_err;
    logic [7:0]    w_b;
    logic [15:0]   w_acc_in, w_acc_out;
    logic [1:0]    w_opcode;
    logic          w_v, w_dig, w_opc, w_cr, w_ovf, w_bad;
    assign w_b      = bus.rx_data;
    assign w_cr     = w_b == ASCII_CR;
    assign w_v      = bus.rx_valid && w_b != ASCII_SP;
    assign w_dig    = w_b >= ASCII_0 && w_b <= ASCII_9;
    assign w_opc    = w_b == ASCII_PLUS || w_b == ASCII_MINUS || w_b == ASCII_STAR;
    assign w_opcode = w_b == ASCII_PLUS ? OP_ADD : w_b == ASCII_MINUS ? OP_SUB : OP_MUL;
    // single accumulator shared between operands
    assign w_acc_in = r_state == ST_OP2 ? r_acc2 : r_acc1;
    assign w_bad    = w_ovf || r_cnt == CW'(MAX_DIGITS);
    dec_digit_acc u_acc (
        .i_acc    (w_acc_in),
        .i_digit  (w_b[3:0]),
        .o_result (w_acc_out),
        .o_ovf    (w_ovf)
    );
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state  <= ST_IDLE;
            r_acc1   <= '0;
            r_acc2   <= '0;
            r_op_w   <= '0;
            r_cnt    <= '0;
            r_err_cr <= 1'b0;
            r_src1   <= '0;
            r_src2   <= '0;
            r_op     <= '0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                ST_IDLE: if (w_v && !w_cr) begin
                    if (w_dig) begin
                        r_state <= ST_OP1;
                        r_acc1  <= {12'd0, w_b[3:0]};
                        r_cnt   <= CW'(1);
                    end else begin
                        r_state  <= ST_ERR;
                        r_err    <= 1'b1;
                        r_err_cr <= 1'b0;
                    end
                end
                ST_OP1: if (w_v) begin
                    if (w_dig && !w_bad) begin
                        r_acc1 <= w_acc_out;
                        r_cnt  <= r_cnt + CW'(1);
                    end else if (w_opc) begin
                        r_state <= ST_OP2;
                        r_op_w  <= w_opcode;
                        r_acc2  <= '0;
                        r_cnt   <= '0;
                    end else begin
                        r_state  <= ST_ERR;
                        r_err    <= 1'b1;
                        r_err_cr <= w_cr;
                    end
                end
                ST_OP2: if (w_v) begin
                    if (w_dig && !w_bad) begin
                        r_acc2 <= w_acc_out;
                        r_cnt  <= r_cnt + CW'(1);
                    end else if (w_cr && r_cnt != '0) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                        r_src1  <= r_acc1;
                        r_src2  <= r_acc2;
                        r_op    <= r_op_w;
                    end else begin
                        r_state  <= ST_ERR;
                        r_err    <= 1'b1;
                        r_err_cr <= w_cr;
                    end
                end
                ST_DONE:  r_state <= ST_IDLE;
                // CR already consumed means the line is over; otherwise skip to its end
                ST_ERR:   r_state <= r_err_cr ? ST_IDLE : ST_FLUSH;
                ST_FLUSH: if (bus.rx_valid && w_cr) r_state <= ST_IDLE;
                default:  r_state <= ST_IDLE;
            endcase
        end
    end
    assign bus.src1        = r_src1;
    assign bus.src2        = r_src2;
    assign bus.op          = r_op;
    assign bus.parser_done = r_done;
    assign bus.parse_err   = r_err;
endmodule

// File: tb/tb_uart_cmd_parser.sv
// tb_uart_cmd_parser: line-level reference model against uart_cmd_parser, directed and random lines
module tb_uart_cmd_parser;
    typedef struct {
        int kind;
        int eidx;
        int v1;
        int v2;
        int op;
    } res_t;
    localparam int MAXD = 5;
    logic clk = 1'b0;
    logic n_rst = 1'b0;
    int n_checks = 0;
    int n_pass = 0;
    int n_done = 0;
    int n_err = 0;
    logic [7:0] q[$];
    logic [15:0] e_src1 = '0;
    logic [15:0] e_src2 = '0;
    logic [1:0] e_op = '0;
    uart_cmd_parser_if bus ();
    uart_cmd_parser #(.MAX_DIGITS(MAXD)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );
    always #5 clk = ~clk;
    always @(negedge clk) begin
        if (bus.parser_done) n_done++;
        if (bus.parse_err) n_err++;
    end
    initial begin
        #5ms;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end
    // kind: 0 empty line, 1 valid command, 2 error at byte index eidx (q.size() means the CR)
    function automatic res_t model(input logic [7:0] s[$]);
        res_t r;
        int stage, cnt, v;
        logic [7:0] c;
        r = '{0, -1, 0, 0, 0};
        stage = 0;
        cnt = 0;
        v = 0;
        for (int i = 0; i <= s.size(); i++) begin
            c = (i == s.size()) ? 8'h0D : s[i];
            if (c == 8'h20) continue;
            if (c >= "0" && c <= "9") begin
                if (stage == 0) stage = 1;
                cnt++;
                v = v * 10 + int'(c) - 48;
                if (cnt > MAXD || v > 65535) begin
                    r.kind = 2;
                    r.eidx = i;
                    return r;
                end
            end else if (c == 8'h0D) begin
                if (stage == 0) return r;
                if (stage == 2 && cnt > 0) begin
                    r.kind = 1;
                    r.v2 = v;
                end else begin
                    r.kind = 2;
                    r.eidx = i;
                end
                return r;
            end else if (stage == 1 && (c == "+" || c == "-" || c == "*")) begin
                r.v1 = v;
                r.op = c == "+" ? 0 : c == "-" ? 1 : 2;
                stage = 2;
                v = 0;
                cnt = 0;
            end else begin
                r.kind = 2;
                r.eidx = i;
                return r;
            end
        end
        return r;
    endfunction
    task automatic set_q(input string s);
        q.delete();
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    endtask
    task automatic gap();
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
    endtask
    task automatic send_raw(input logic [7:0] b, output logic [1:0] p);
        bus.rx_data = b;
        bus.rx_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
        p = {bus.parser_done, bus.parse_err};
    endtask
    task automatic test_line(input string name);
        res_t r;
        int nd, ne;
        logic [1:0] got, exp;
        r = model(q);
        nd = n_done;
        ne = n_err;
        for (int i = 0; i <= q.size(); i++) begin
            send_raw((i == q.size()) ? 8'h0D : q[i], got);
            exp = {r.kind == 1 && i == q.size(), r.kind == 2 && i == r.eidx};
            n_checks++;
            if (got !== exp) $display("FAIL %s pulses byte%0d got=%b exp=%b", name, i, got, exp);
            else n_pass++;
            gap();
        end
        n_checks++;
        if (n_done - nd !== int'(r.kind == 1) || n_err - ne !== int'(r.kind == 2))
            $display("FAIL %s pulse_count done=%0d err=%0d exp_kind=%0d", name, n_done - nd, n_err - ne, r.kind);
        else n_pass++;
        if (r.kind == 1) begin
            e_src1 = 16'(r.v1);
            e_src2 = 16'(r.v2);
            e_op = 2'(r.op);
        end
        n_checks++;
        if ({bus.src1, bus.src2, bus.op} !== {e_src1, e_src2, e_op})
            $display("FAIL %s outputs got=%h/%h/%0d exp=%h/%h/%0d", name, bus.src1, bus.src2, bus.op, e_src1, e_src2, e_op);
        else n_pass++;
    endtask
    task automatic test_reset();
        bus.rx_valid = 1'b0;
        bus.rx_data = 8'h00;
        n_rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({bus.src1, bus.src2, bus.op, bus.parser_done, bus.parse_err} !== 36'd0)
            $display("FAIL reset_outputs got=%h/%h/%0d/%b%b exp=0", bus.src1, bus.src2, bus.op, bus.parser_done, bus.parse_err);
        else n_pass++;
        n_rst = 1'b1;
        gap();
        set_q("");
        test_line("reset_empty");
    endtask
    task automatic test_directed();
        set_q("12*34");    test_line("mul_12_34");
        set_q("65535+1");  test_line("max_add");
        set_q("00007-3");  test_line("leading_zeros");
        set_q("65536*2");  test_line("overflow");
        set_q("3-4");      test_line("after_overflow");
        set_q("12*");      test_line("missing_op2");
        set_q("9*9");      test_line("after_missing");
        set_q("1/2");      test_line("bad_op");
        set_q("123456+1"); test_line("too_many_digits");
        set_q("4+000001"); test_line("too_many_digits2");
        set_q(" 7 * 8 ");  test_line("spaces");
        set_q("");         test_line("bare_cr");
        set_q("+5");       test_line("op_first");
        set_q("5+-3");     test_line("double_op");
        set_q("99999-0");  test_line("overflow_5dig");
    endtask
    task automatic push_num(input int nd);
        for (int k = 0; k < nd; k++) begin
            if ($urandom_range(0, 5) == 0) q.push_back(8'h20);
            q.push_back(8'(48 + $urandom_range(0, 9)));
        end
    endtask
    task automatic test_random();
        logic [7:0] ops[5];
        ops = '{8'h2B, 8'h2D, 8'h2A, 8'h2F, 8'h2B};
        for (int n = 0; n < 250; n++) begin
            q.delete();
            if ($urandom_range(0, 4) == 0) q.push_back(8'h20);
            push_num($urandom_range(0, 9) == 0 ? 0 : $urandom_range(1, 6));
            if ($urandom_range(0, 3) == 0) q.push_back(8'h20);
            if ($urandom_range(0, 12) != 0) q.push_back(ops[$urandom_range(0, 4)]);
            push_num($urandom_range(0, 9) == 0 ? 0 : $urandom_range(1, 6));
            if ($urandom_range(0, 10) == 0) q.push_back(8'(33 + $urandom_range(0, 90)));
            if ($urandom_range(0, 3) == 0) q.push_back(8'h20);
            test_line($sformatf("rand%0d", n));
        end
    endtask
    task automatic test_back_to_back();
        logic [1:0] p;
        set_q("4+4");
        foreach (q[i]) begin
            send_raw(q[i], p);
            gap();
        end
        send_raw(8'h0D, p);
        n_checks++;
        if (p !== 2'b10) $display("FAIL b2b_done got=%b exp=10", p);
        else n_pass++;
        e_src1 = 16'd4;
        e_src2 = 16'd4;
        e_op = 2'd0;
        send_raw("9", p);
        n_checks++;
        if (p !== 2'b00) $display("FAIL b2b_in_done got=%b exp=00", p);
        else n_pass++;
        gap();
        set_q("2+3");
        test_line("b2b_after_done");
        send_raw("+", p);
        n_checks++;
        if (p !== 2'b01) $display("FAIL b2b_err got=%b exp=01", p);
        else n_pass++;
        send_raw(8'h0D, p);
        gap();
        set_q("5*6");
        q.push_back(8'h0D);
        foreach (q[i]) begin
            send_raw(q[i], p);
            n_checks++;
            if (p !== 2'b00) $display("FAIL b2b_flush byte%0d got=%b exp=00", i, p);
            else n_pass++;
            gap();
        end
        set_q("7+1");
        test_line("b2b_after_flush");
    endtask
    task automatic test_reset_mid();
        logic [1:0] p;
        int nd, ne;
        nd = n_done;
        ne = n_err;
        set_q("12*3");
        foreach (q[i]) begin
            send_raw(q[i], p);
            gap();
        end
        n_rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({bus.src1, bus.src2, bus.op, bus.parser_done, bus.parse_err} !== 36'd0)
            $display("FAIL reset_mid_outputs got=%h/%h/%0d/%b%b exp=0", bus.src1, bus.src2, bus.op, bus.parser_done, bus.parse_err);
        else n_pass++;
        n_rst = 1'b1;
        e_src1 = '0;
        e_src2 = '0;
        e_op = '0;
        gap();
        n_checks++;
        if (n_done != nd || n_err != ne) $display("FAIL reset_mid_pulses done=%0d err=%0d exp=0", n_done - nd, n_err - ne);
        else n_pass++;
        set_q("5+5");
        test_line("after_reset");
    endtask
    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
